md_unit: RTL and testbench
==========================

# md_unit

- Multi-cycle multiply/divide unit with the HI/LO register pair, sitting in the EX stage.
- Consumes the `md`/`mt`/`mf` strobes and the 4-bit `ALUXOp` encoding that the instruction decoder emits, and executes them.
- Provides the `Busy` handshake that the hazard unit uses to stall later HI/LO instructions.
- Returns HI or LO for `mfhi`/`mflo`.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult, multu, madd.
- `DIV_CYCLES`, 10: busy cycles for div, divu.
- `clk` in 1: single clock; every register updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `Start` in 1: the decoder's `md` strobe, qualified for EX; launches mult/multu/div/divu/madd.
- `Mt` in 1: the decoder's `mt` strobe, qualified for EX; launches mthi/mtlo.
- `ALUXOp` in 4: operation code.
  - 0000 mult, 0001 multu, 0010 div, 0011 divu.
  - 0100 mthi, 0101 mtlo, 0110 mfhi, 0111 mflo.
  - 1000 madd.
  - All other codes are no-ops.
- `A` in 32: rs operand (forwarded).
- `B` in 32: rt operand (forwarded).
- `Flush` in 1: exception/interrupt cancel for the op in flight.
- `Busy` out 1: operation in progress.
- `Out` out 32: HI when `ALUXOp`=0110, LO when `ALUXOp`=0111, 0 otherwise.
- `HI` out 32: architectural HI register.
- `LO` out 32: architectural LO register.

## Operation
- States: IDLE and RUN.
  - RUN holds a down-counter, the latched op, and the result computed at launch.
- Launch rules:
  - IDLE and `Start` and `!Flush` and `ALUXOp` in {0000,0001,0010,0011,1000}: latch the op and operands, load the counter with the op's cycle count, go to RUN.
  - IDLE and `Mt` and `!Flush`: at the next edge HI←A (0100) or LO←A (0101). No Busy.
  - `Start` and `Mt` both set: `Start` wins.
- RUN:
  - The counter decrements each cycle.
  - On the edge where the counter reaches 1→0: commit HI/LO, return to IDLE.
  - `Start`/`Mt` are ignored in RUN. The hazard unit guarantees they do not occur; if they do, there is no effect.
- Arithmetic, all 64-bit results:
  - mult: {HI,LO} = signed A × signed B.
  - multu: {HI,LO} = unsigned A × unsigned B.
  - madd: {HI,LO} += signed A × signed B, mod 2^64, using the HI/LO values at commit time.
  - div: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
    - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (div or divu): Busy runs the full `DIV_CYCLES`, HI/LO unchanged.
- Flush:
  - Flush in RUN: go to IDLE at the next edge, no commit, HI/LO unchanged.
  - Flush in the same cycle as `Start` or `Mt`: no launch, no write.
- `Out` is combinational from the HI/LO registers. Stalling mfhi/mflo while `Busy` is the hazard unit's job.

## Timing
- Reset (`rst_n`=0, asynchronous): HI=0, LO=0, Busy=0, state IDLE, counter 0, `Out`=0. Asserting reset mid-operation aborts it with no commit.
- Launch sampled at edge E0. Busy is high from the cycle after E0 for exactly N cycles (N = `MULT_CYCLES` or `DIV_CYCLES`).
- The new HI/LO is visible in the same cycle that Busy falls. A `Start` in that cycle is accepted.
- Busy is a registered output and never combinationally depends on `Start`.
- mthi/mtlo: value visible one cycle after the sampling edge.
- Flush in RUN: Busy=0 in the cycle after the flush edge.

## Test plan
- Reset, then mult A=0xFFFFFFFF B=2:
  - Busy high exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - Repeat with multu → HI=1, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7) B=2:
  - Busy high 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7 B=2 → LO=3, HI=1.
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Preload via mthi 0x0, mtlo 0xFFFFFFFF (each visible next cycle), then madd A=1 B=1:
  - After 5 busy cycles HI=1, LO=0.
  - mfhi → Out=1; mflo → Out=0.
- Divide by zero:
  - Preload HI=0x1234, LO=0x5678, then div A=9 B=0.
  - Busy 10 cycles, HI/LO unchanged; mflo → Out=0x5678.
- div launched, Flush asserted at busy cycle 4:
  - Busy drops the next cycle, HI/LO unchanged.
  - `Start`+`Flush` in the same cycle: no Busy, no change.
- Drop `rst_n` asynchronously mid-mult: HI=LO=0 and Busy=0 immediately, without waiting for a clock edge.
- Back-to-back mult issued in the cycle Busy falls: accepted, second result correct.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/multu/div/divu/madd unit owning HI/LO, with Busy handshake and mfhi/mflo readback
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic        Mt,
  input  logic [3:0]  ALUXOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic [31:0] Out,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic madd, skip, is_mul, is_div, sgn, na, nb, go;
  logic [63:0] acc, prod, res;
  logic [31:0] ma, mb, dv, uq, ur;
  always_comb begin
    is_mul = ALUXOp == 4'b0000 || ALUXOp == 4'b0001 || ALUXOp == 4'b1000;
    is_div = ALUXOp == 4'b0010 || ALUXOp == 4'b0011;
    sgn = ALUXOp != 4'b0001 && ALUXOp != 4'b0011;
    prod = sgn ? {{32{A[31]}}, A} * {{32{B[31]}}, B} : {32'b0, A} * {32'b0, B};
    na = sgn && A[31];
    nb = sgn && B[31];
    ma = na ? -A : A;
    mb = nb ? -B : B;
    dv = B == 32'b0 ? 32'd1 : mb;
    uq = ma / dv;
    ur = ma % dv;
    res = is_div ? {na ? -ur : ur, (na ^ nb) ? -uq : uq} : prod;
    go = Start && !Flush && (is_mul || is_div);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      HI <= '0;
      LO <= '0;
      acc <= '0;
      madd <= 1'b0;
      skip <= 1'b0;
    end else if (state == IDLE) begin
      if (go) begin
        state <= RUN;
        cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        acc <= res;
        madd <= ALUXOp == 4'b1000;
        skip <= is_div && B == 32'b0;
      end else if (Mt && !Start && !Flush) begin
        if (ALUXOp == 4'b0100) HI <= A;
        if (ALUXOp == 4'b0101) LO <= A;
      end
    end else if (Flush) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state <= IDLE;
        if (madd) {HI, LO} <= {HI, LO} + acc;
        else if (!skip) {HI, LO} <= acc;
      end
    end
  end
  assign Busy = state == RUN;
  assign Out = ALUXOp == 4'b0110 ? HI : ALUXOp == 4'b0111 ? LO : 32'b0;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit
module tb_md_unit;
  logic clk = 1'b0, rst_n = 1'b0, Start = 1'b0, Mt = 1'b0, Flush = 1'b0;
  logic [3:0] ALUXOp = 4'h6;
  logic [31:0] A = '0, B = '0;
  logic Busy;
  logic [31:0] Out, HI, LO;
  int tests = 0, fails = 0, n;
  md_unit dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Mt(Mt), .ALUXOp(ALUXOp),
    .A(A), .B(B), .Flush(Flush), .Busy(Busy), .Out(Out), .HI(HI), .LO(LO)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUXOp = op;
    A = a;
    B = b;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    ALUXOp = 4'hF;
    chk("busy_rise", {31'b0, Busy}, 32'd1);
  endtask
  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (Busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask
  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int exp_n, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    launch(op, a, b);
    wait_busy(n);
    chk({tag, "_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_lo"}, LO, exp_lo);
  endtask
  task automatic mt(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] exp_hi,
                    input logic [31:0] exp_lo);
    ALUXOp = op;
    A = a;
    Mt = 1'b1;
    @(negedge clk);
    Mt = 1'b0;
    ALUXOp = 4'hF;
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_lo"}, LO, exp_lo);
  endtask
  initial begin
    #1;
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_out", Out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ALUXOp = 4'hF;
    @(negedge clk);
    run("mult", 4'b0000, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run("multu", 4'b0001, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    run("div", 4'b0010, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divu", 4'b0011, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run("div_ovf", 4'b0010, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
    mt("mthi0", 4'b0100, 32'h0, 32'h0, 32'h80000000);
    mt("mtlo", 4'b0101, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF);
    run("madd", 4'b1000, 32'd1, 32'd1, 5, 32'd1, 32'd0);
    ALUXOp = 4'b0110;
    #1 chk("mfhi", Out, 32'd1);
    ALUXOp = 4'b0111;
    #1 chk("mflo", Out, 32'd0);
    ALUXOp = 4'hF;
    #1 chk("out_noop", Out, 32'd0);
    @(negedge clk);
    mt("mthi", 4'b0100, 32'h1234, 32'h1234, 32'h0);
    mt("mtlo2", 4'b0101, 32'h5678, 32'h1234, 32'h5678);
    run("divz", 4'b0010, 32'd9, 32'd0, 10, 32'h1234, 32'h5678);
    ALUXOp = 4'b0111;
    #1 chk("divz_mflo", Out, 32'h5678);
    ALUXOp = 4'hF;
    @(negedge clk);
    launch(4'b0010, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    chk("flush_busy4", {31'b0, Busy}, 32'd1);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    chk("flush_busy", {31'b0, Busy}, 32'd0);
    repeat (12) @(negedge clk);
    chk("flush_hi", HI, 32'h1234);
    chk("flush_lo", LO, 32'h5678);
    ALUXOp = 4'b0000;
    A = 32'd3;
    B = 32'd3;
    Start = 1'b1;
    Flush = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    chk("sflush_busy", {31'b0, Busy}, 32'd0);
    ALUXOp = 4'b0100;
    A = 32'hDEAD;
    Mt = 1'b1;
    @(negedge clk);
    Mt = 1'b0;
    Flush = 1'b0;
    ALUXOp = 4'hF;
    chk("mflush_hi", HI, 32'h1234);
    chk("mflush_lo", LO, 32'h5678);
    launch(4'b0000, 32'd3, 32'd4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", HI, 32'h0);
    chk("arst_lo", LO, 32'h0);
    chk("arst_busy", {31'b0, Busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_nocommit", LO, 32'h0);
    run("b2b_first", 4'b0000, 32'd3, 32'd4, 5, 32'd0, 32'd12);
    run("b2b_second", 4'b0000, 32'hFFFFFFFB, 32'd6, 5, 32'hFFFFFFFF, 32'hFFFFFFE2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
